// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
//   Start/done handshake bundle between the arithmetic-unit controller and the
//   sequential divider.
//
//   Handshake: the controller raises start with dividend/divisor valid; the
//   divider accepts it on a rising edge only while busy=0 (IDLE or DONE state).
//   Once accepted, busy stays high for the whole calculation and start is
//   ignored. done is a one-cycle pulse; quotient/remainder/div_by_zero are
//   valid from that cycle and hold until the next completion or reset.
//
//   Signals:
//     start        controller -> divider  request
//     dividend     controller -> divider  numerator  (DIVIDEND_WIDTH)
//     divisor      controller -> divider  denominator (DIVISOR_WIDTH)
//     busy         divider -> controller  calculation in progress
//     done         divider -> controller  one-cycle result pulse
//     quotient     divider -> controller  DIVIDEND_WIDTH
//     remainder    divider -> controller  DIVISOR_WIDTH
//     div_by_zero  divider -> controller  last result had a zero divisor
// ----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
);
  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      busy;
  logic                      done;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider, one quotient bit per clock. Recovers
//   quotient and remainder from a product-width dividend and a narrow divisor.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     bus        seq_divider_if.slave (start/dividend/divisor in,
//                busy/done/quotient/remainder/div_by_zero out)
//     state_dbg  current FSM state (0=IDLE, 1=CALC, 2=DONE)
//
//   Optional feature: define SEQ_DIVIDER_SIGNED_EN for two's-complement
//   operands. Magnitudes are taken at capture, the unsigned core is unchanged,
//   and signs are applied on the completion edge (quotient truncates toward
//   zero, remainder follows the dividend sign). Undefined: purely unsigned.
//
//   Latency: start accepted at edge E -> done high in the cycle after
//   edge E+DIVIDEND_WIDTH. A zero divisor skips CALC and goes straight to DONE.
// ----------------------------------------------------------------------------
module seq_divider #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_if.slave       bus,
  output logic [1:0]         state_dbg
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   shreg;      // dividend bits shifting out, quotient bits in
  logic [VW-1:0]   dvsr;
  logic [VW:0]     prem;       // partial remainder, one guard bit
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   quotient_r;
  logic [VW-1:0]   remainder_r;
  logic            dbz_r;
  logic            busy_r;
  logic            done_r;

  // One restoring step on {prem, shreg}
  logic [VW:0]     shifted;
  logic [VW+1:0]   diff;
  logic            nonneg;
  logic [VW:0]     prem_nxt;
  logic [DW-1:0]   shreg_nxt;

  always_comb begin
    shifted   = {prem[VW-1:0], shreg[DW-1]};
    diff      = {1'b0, shifted} - {2'b00, dvsr};
    nonneg    = ~diff[VW+1];
    prem_nxt  = nonneg ? diff[VW:0] : shifted;
    shreg_nxt = {shreg[DW-2:0], nonneg};
  end

  // Operand magnitudes at capture and final results at completion
  logic [DW-1:0]   a_mag;
  logic [VW-1:0]   b_mag;
  logic [DW-1:0]   q_fin;
  logic [VW-1:0]   r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    a_mag = bus.dividend[DW-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag = bus.divisor[VW-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    q_fin = neg_q ? (~shreg_nxt + 1'b1) : shreg_nxt;
    r_fin = neg_r ? (~prem_nxt[VW-1:0] + 1'b1) : prem_nxt[VW-1:0];
  end

  // Sign flags latched with the operands; the most-negative/-1 case needs no
  // special path: |min| = min in DW bits and the signs agree, so q = min, r = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state != CALC && bus.start) begin
      neg_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
      neg_r <= bus.dividend[DW-1];
    end
  end
`else
  always_comb begin
    a_mag = bus.dividend;
    b_mag = bus.divisor;
    q_fin = shreg_nxt;
    r_fin = prem_nxt[VW-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      dvsr        <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            shreg <= a_mag;
            dvsr  <= b_mag;
            prem  <= '0;
            cnt   <= CW'(DW);
            if (bus.divisor == '0) begin
              // Zero divisor: result is available immediately
              quotient_r  <= '1;
              remainder_r <= bus.dividend[VW-1:0];
              dbz_r       <= 1'b1;
              state       <= DONE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              state  <= CALC;
              busy_r <= 1'b1;
              done_r <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        CALC: begin
          shreg <= shreg_nxt;
          prem  <= prem_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient_r  <= q_fin;
            remainder_r <= r_fin;
            dbz_r       <= 1'b0;
            state       <= DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Directed-vector bench for seq_divider (16/8). Drivers push the expected
//   {div_by_zero, quotient, remainder} into exp_q; a monitor pops and compares
//   on every done pulse. Drivers also check latency, busy and output hold.
// ----------------------------------------------------------------------------
module tb_seq_divider;
  localparam int DW = 16;
  localparam int VW = 8;
  localparam int W  = 1 + DW + VW;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  seq_divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus ();

  seq_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [DW-1:0] last_q = '0;
  logic [VW-1:0] last_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [DW-1:0] q, input logic [VW-1:0] r,
                                        input logic dbz);
    return {dbz, q, r};
  endfunction

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("quotient",    32'(bus.quotient),    32'(e[VW +: DW]));
        check("remainder",   32'(bus.remainder),   32'(e[VW-1:0]));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e[W-1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one operation and follow it to completion. exp_lat is the number of
  // edges after the accepting edge E until done is seen (16, or 0 for /0).
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er,
                        input logic ed, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    exp_q.push_back(pack(eq, er, ed));
    @(negedge clk);                 // first cycle after edge E
    bus.start = 1'b0;
    if (exp_lat > 0) begin
      check("busy_in_calc", 32'(bus.busy), 32'd1);
      check("state_calc",   32'(state_dbg), 32'd1);
      check("hold_quotient", 32'(bus.quotient), 32'(last_q));
      check("hold_remainder", 32'(bus.remainder), 32'(last_r));
    end
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    last_q = eq;
    last_r = er;
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("hold_after_done", 32'(bus.quotient), 32'(eq));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(bus.busy),        32'd0);
    check("rst_done",      32'(bus.done),        32'd0);
    check("rst_quotient",  32'(bus.quotient),    32'd0);
    check("rst_remainder", 32'(bus.remainder),   32'd0);
    check("rst_dbz",       32'(bus.div_by_zero), 32'd0);
    check("rst_state",     32'(state_dbg),       32'd0);
    rst = 1'b0;

    // Basic and boundary vectors
    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(16'hFFFF, 8'hFF, 16'h0001, 8'h00, 1'b0, 16);   // -1 / -1
`else
    run_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16);
`endif
    run_op(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 16);
    run_op(16'h04D2, 8'h00, 16'hFFFF, 8'hD2, 1'b1, 0);
    run_op(16'd200,  8'd3,  16'd66,   8'd2,  1'b0, 16);

    // start held high with operands changed mid-CALC, then back-to-back
    @(negedge clk);
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    exp_q.push_back(pack(16'd142, 8'd6, 1'b0));
    repeat (5) @(negedge clk);
    bus.dividend = 16'd200;
    bus.divisor  = 8'd3;
    exp_q.push_back(pack(16'd66, 8'd2, 1'b0));
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", 32'(bus.done), 32'd1);
    @(negedge clk);                 // start was high in the DONE cycle
    bus.start = 1'b0;
    check("b2b_done_drop", 32'(bus.done), 32'd0);
    check("b2b_busy",      32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_latency", 32'(n), 32'd16);
    last_q = 16'd66;
    last_r = 8'd2;

    // Reset in the 8th cycle of CALC
    @(negedge clk);
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",      32'(bus.busy),        32'd0);
    check("abort_done",      32'(bus.done),        32'd0);
    check("abort_quotient",  32'(bus.quotient),    32'd0);
    check("abort_remainder", 32'(bus.remainder),   32'd0);
    check("abort_dbz",       32'(bus.div_by_zero), 32'd0);
    check("abort_state",     32'(state_dbg),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    repeat (20) @(negedge clk);     // monitor flags any stray done here
    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(16'hFC18, 8'h07, 16'hFF72, 8'hFA, 1'b0, 16);   // -1000 / 7
    run_op(16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 16);   // min / -1
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
